// File: rtl/dw_div_seq.sv
// Sequential restoring divider: quotient = a / b, remainder = a % b in exactly NUM_CYC cycles.
// Define DW_DIV_SEQ_HOLD_EN to make the hold input freeze an operation in progress.
module dw_div_seq #(
    parameter int unsigned A_WIDTH     = 32,
    parameter int unsigned B_WIDTH     = 32,
    parameter int unsigned TC_MODE     = 0,
    parameter int unsigned NUM_CYC     = 10,
    parameter int unsigned INPUT_MODE  = 1,
    parameter int unsigned OUTPUT_MODE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               start,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               complete,
    output logic               divide_by_0,
    output logic [A_WIDTH-1:0] quotient,
    output logic [B_WIDTH-1:0] remainder
);

    localparam int unsigned K  = (A_WIDTH + NUM_CYC - 2) / (NUM_CYC - 1);
    localparam int unsigned N  = K * (NUM_CYC - 1);
    localparam int unsigned CW = $clog2(NUM_CYC);
    localparam logic [CW-1:0] LAST = CW'(NUM_CYC - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]       dvd_q, dvd_d;
    logic [B_WIDTH-1:0] rem_q, rem_d;
    logic [A_WIDTH-1:0] a_q, a_d, quo_q, quo_d;
    logic [B_WIDTH-1:0] b_q, b_d, rmd_q, rmd_d;
    logic               cpl_q, cpl_d, dz_q, dz_d;

    logic [A_WIDTH-1:0] a_op, a_mag_in, q_mag;
    logic [B_WIDTH-1:0] b_op, b_mag;
    logic               a_neg, b_neg, step_en;
    logic [B_WIDTH:0]   rem_sh;
    logic [N-1:0]       dvd_w;
    logic [B_WIDTH-1:0] rem_w;

`ifdef DW_DIV_SEQ_HOLD_EN
    assign step_en = ~hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign step_en     = 1'b1;
`endif

    assign a_op     = (INPUT_MODE == 1) ? a_q : a;
    assign b_op     = (INPUT_MODE == 1) ? b_q : b;
    assign a_neg    = (TC_MODE == 1) && a_op[A_WIDTH-1];
    assign b_neg    = (TC_MODE == 1) && b_op[B_WIDTH-1];
    assign a_mag_in = ((TC_MODE == 1) && a[A_WIDTH-1]) ? -a : a;
    assign b_mag    = b_neg ? -b_op : b_op;
    assign q_mag    = dvd_q[A_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cpl_d   = cpl_q;
        dz_d    = dz_q;
        dvd_w   = dvd_q;
        rem_w   = rem_q;
        rem_sh  = '0;

        // Dividend is zero-extended to K*(NUM_CYC-1) bits, so surplus steps only shift in leading zeros.
        for (int unsigned i = 0; i < K; i++) begin
            rem_sh = {rem_w, dvd_w[N-1]};
            dvd_w  = {dvd_w[N-2:0], 1'b0};
            if (rem_sh >= {1'b0, b_mag}) begin
                rem_sh   = rem_sh - {1'b0, b_mag};
                dvd_w[0] = 1'b1;
            end
            rem_w = rem_sh[B_WIDTH-1:0];
        end

        if (state_q == BUSY && step_en) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cpl_d   = 1'b1;
                if (b_op == '0) begin
                    dz_d  = 1'b1;
                    quo_d = '1;
                    rmd_d = a_op[B_WIDTH-1:0];
                end else begin
                    dz_d  = 1'b0;
                    quo_d = (a_neg ^ b_neg) ? -q_mag : q_mag;
                    rmd_d = a_neg ? -rem_q : rem_q;
                end
            end else begin
                dvd_d = dvd_w;
                rem_d = rem_w;
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (start) begin
            state_d              = BUSY;
            cnt_d                = '0;
            cpl_d                = 1'b0;
            dvd_d                = '0;
            dvd_d[A_WIDTH-1:0]   = a_mag_in;
            rem_d                = '0;
            a_d                  = a;
            b_d                  = b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cpl_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cpl_q   <= cpl_d;
            dz_q    <= dz_d;
        end
    end

    assign complete    = cpl_q;
    assign divide_by_0 = dz_q;
    assign quotient    = (OUTPUT_MODE == 0 && state_q == BUSY) ? dvd_q[A_WIDTH-1:0] : quo_q;
    assign remainder   = (OUTPUT_MODE == 0 && state_q == BUSY) ? rem_q : rmd_q;

endmodule

// File: tb/tb_dw_div_seq.sv
// Bench for dw_div_seq: unsigned and two's-complement instances driven together, checked against
// integer-arithmetic reference results.
module tb_dw_div_seq;
    localparam int LAT = 10;
`ifdef DW_DIV_SEQ_HOLD_EN
    localparam int HOLD_LAT = 13;
`else
    localparam int HOLD_LAT = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n, hold, start;
    logic [31:0] a, b;
    logic        cu, dzu, cs, dzs;
    logic [31:0] qu, ru, qs, rs;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dw_div_seq u_uns (
        .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .a(a), .b(b),
        .complete(cu), .divide_by_0(dzu), .quotient(qu), .remainder(ru)
    );

    dw_div_seq #(.TC_MODE(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .a(a), .b(b),
        .complete(cs), .divide_by_0(dzs), .quotient(qs), .remainder(rs)
    );

    function automatic void model(input logic [31:0] av, input logic [31:0] bv, input bit sgn,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        dz = (bv == 32'd0);
        q  = '1;
        r  = av;
        if (bv != 32'd0) begin
            if (sgn) begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end else begin
                q = av / bv;
                r = av % bv;
            end
        end
    endfunction

    // Launch one division; lat = cycles from the last start-sampling edge to complete rising (-1 on timeout).
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int nstart,
                         input int hold_at, input int hold_len, output int lat);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        repeat (nstart) @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c == hold_at) hold = 1'b1;
            if (c == hold_at + hold_len) hold = 1'b0;
            @(posedge clk);
            #1;
            if (cu) begin
                lat = c;
                break;
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        total++;
        if ({cu, dzu, qu, ru} !== 66'd0) begin
            bad++; $display("FAIL reset_uns: got c=%b dz=%b q=%h r=%h expected all 0", cu, dzu, qu, ru);
        end
        total++;
        if ({cs, dzs, qs, rs} !== 66'd0) begin
            bad++; $display("FAIL reset_sgn: got c=%b dz=%b q=%h r=%h expected all 0", cs, dzs, qs, rs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF9};
        logic [31:0] tbv[4] = '{32'd7,   32'hFFFF_FFFF, 32'd0, 32'd2};
        int          tn [4] = '{1, 6, 1, 1};
        logic [31:0] equ, eru, eqs, ers;
        logic        edu, eds;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tbv[i], tn[i], 0, 0, lat);
            model(ta[i], tbv[i], 1'b0, equ, eru, edu);
            model(ta[i], tbv[i], 1'b1, eqs, ers, eds);
            total++; if (lat !== LAT) begin bad++; $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
            total++; if (cs !== 1'b1) begin bad++; $display("FAIL dir_cpl_sgn[%0d]: got %b expected 1", i, cs); end
            total++; if (qu !== equ) begin bad++; $display("FAIL dir_q_uns[%0d]: got %h expected %h", i, qu, equ); end
            total++; if (ru !== eru) begin bad++; $display("FAIL dir_r_uns[%0d]: got %h expected %h", i, ru, eru); end
            total++; if (dzu !== edu) begin bad++; $display("FAIL dir_dz_uns[%0d]: got %b expected %b", i, dzu, edu); end
            total++; if (qs !== eqs) begin bad++; $display("FAIL dir_q_sgn[%0d]: got %h expected %h", i, qs, eqs); end
            total++; if (rs !== ers) begin bad++; $display("FAIL dir_r_sgn[%0d]: got %h expected %h", i, rs, ers); end
            total++; if (dzs !== eds) begin bad++; $display("FAIL dir_dz_sgn[%0d]: got %b expected %b", i, dzs, eds); end
        end
    endtask

    task automatic test_random();
        logic [31:0] av, bv, equ, eru, eqs, ers;
        logic        edu, eds;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = $urandom;
                1:       bv = $urandom_range(1, 15);
                2:       bv = 32'd0;
                default: bv = 32'd0 - $urandom_range(1, 9);
            endcase
            do_op(av, bv, $urandom_range(1, 3), 0, 0, lat);
            model(av, bv, 1'b0, equ, eru, edu);
            model(av, bv, 1'b1, eqs, ers, eds);
            total++; if (lat !== LAT) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", i, lat, LAT); end
            total++; if ({qu, ru, dzu} !== {equ, eru, edu}) begin
                bad++; $display("FAIL rnd_uns[%0d] a=%h b=%h: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                                i, av, bv, qu, ru, dzu, equ, eru, edu);
            end
            total++; if ({qs, rs, dzs} !== {eqs, ers, eds}) begin
                bad++; $display("FAIL rnd_sgn[%0d] a=%h b=%h: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                                i, av, bv, qs, rs, dzs, eqs, ers, eds);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av, bv, equ, eru, eqs, ers;
        logic        edu, eds;
        int          lat;
        @(negedge clk);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if ({cu, cs} !== 2'b00) begin bad++; $display("FAIL abort_busy_cpl: got %b expected 00", {cu, cs}); end
        av = $urandom; bv = $urandom_range(1, 1000);
        do_op(av, bv, 1, 0, 0, lat);
        model(av, bv, 1'b0, equ, eru, edu);
        model(av, bv, 1'b1, eqs, ers, eds);
        total++; if (lat !== LAT) begin bad++; $display("FAIL abort_lat: got %0d expected %0d", lat, LAT); end
        total++; if ({qu, ru} !== {equ, eru}) begin bad++; $display("FAIL abort_uns: got %h/%h expected %h/%h", qu, ru, equ, eru); end
        total++; if ({qs, rs} !== {eqs, ers}) begin bad++; $display("FAIL abort_sgn: got %h/%h expected %h/%h", qs, rs, eqs, ers); end
    endtask

    task automatic test_hold();
        logic [31:0] av, bv, equ, eru, eqs, ers;
        logic        edu, eds;
        int          lat;
        av = $urandom; bv = $urandom_range(1, 50000);
        do_op(av, bv, 1, 4, 3, lat);
        model(av, bv, 1'b0, equ, eru, edu);
        model(av, bv, 1'b1, eqs, ers, eds);
        total++; if (lat !== HOLD_LAT) begin bad++; $display("FAIL hold_lat: got %0d expected %0d", lat, HOLD_LAT); end
        total++; if ({qu, ru} !== {equ, eru}) begin bad++; $display("FAIL hold_uns: got %h/%h expected %h/%h", qu, ru, equ, eru); end
        total++; if ({qs, rs} !== {eqs, ers}) begin bad++; $display("FAIL hold_sgn: got %h/%h expected %h/%h", qs, rs, eqs, ers); end
    endtask

    task automatic test_capture();
        logic [31:0] av, bv, equ, eru, eqs, ers;
        logic        edu, eds;
        int          lat;
        av = $urandom; bv = $urandom_range(3, 70000);
        model(av, bv, 1'b0, equ, eru, edu);
        model(av, bv, 1'b1, eqs, ers, eds);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = ~av; b = bv + 32'd1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (cu) begin
                lat = c;
                break;
            end
        end
        total++; if (lat !== LAT) begin bad++; $display("FAIL cap_lat: got %0d expected %0d", lat, LAT); end
        total++; if ({qu, ru, qs, rs} !== {equ, eru, eqs, ers}) begin
            bad++; $display("FAIL cap_result: got %h %h %h %h expected %h %h %h %h", qu, ru, qs, rs, equ, eru, eqs, ers);
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if ({cu, cs} !== 2'b11) begin bad++; $display("FAIL idle_cpl: got %b expected 11", {cu, cs}); end
        total++; if ({qu, ru, qs, rs} !== {equ, eru, eqs, ers}) begin
            bad++; $display("FAIL idle_hold: got %h %h %h %h expected %h %h %h %h", qu, ru, qs, rs, equ, eru, eqs, ers);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] av, bv, equ, eru, eqs, ers;
        logic        edu, eds;
        int          lat;
        @(negedge clk);
        a = $urandom; b = $urandom_range(1, 9); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if ({cu, dzu, qu, ru, cs, dzs, qs, rs} !== 132'd0) begin
            bad++; $display("FAIL rst_mid: got %b %b %h %h %b %b %h %h expected all 0", cu, dzu, qu, ru, cs, dzs, qs, rs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        av = $urandom; bv = 32'd0 - $urandom_range(1, 300);
        do_op(av, bv, 1, 0, 0, lat);
        model(av, bv, 1'b0, equ, eru, edu);
        model(av, bv, 1'b1, eqs, ers, eds);
        total++; if (lat !== LAT) begin bad++; $display("FAIL rst_fresh_lat: got %0d expected %0d", lat, LAT); end
        total++; if ({qu, ru, qs, rs} !== {equ, eru, eqs, ers}) begin
            bad++; $display("FAIL rst_fresh_result: got %h %h %h %h expected %h %h %h %h", qu, ru, qs, rs, equ, eru, eqs, ers);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_capture();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dw_div_seq.md
# dw_div_seq

Sequential integer divider computing `quotient = a / b` and `remainder = a % b` over a fixed, parameterised number of clock cycles. It is the iterative divide unit for the CPU's M-extension execute path, instantiated next to the multipliers. The operand width and latency are set at elaboration time. It uses a start/complete handshake with optional hold, registered inputs and outputs, and flags divide-by-zero.

## Interface
Parameters:
- `A_WIDTH`, 32: dividend and quotient width.
- `B_WIDTH`, 32: divisor and remainder width. Must be at most `A_WIDTH`.
- `TC_MODE`, 0: operand interpretation. 0 = unsigned; 1 = two's complement.
- `NUM_CYC`, 10: cycles from start to complete. Legal range is 3 to `A_WIDTH`.
- `INPUT_MODE`, 1: operand capture. 1 = `a`/`b` registered on start; 0 = used combinationally, and the caller must hold them stable until complete.
- `OUTPUT_MODE`, 1: result presentation. 1 = results registered and updated only at completion; 0 = internal partial results visible while busy.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `hold`, input, 1: freeze the operation in progress.
- `start`, input, 1: begin a new division.
- `a`, input, `A_WIDTH`: dividend.
- `b`, input, `B_WIDTH`: divisor.
- `complete`, output, 1: result valid; unit idle.
- `divide_by_0`, output, 1: the completed operation had `b == 0`.
- `quotient`, output, `A_WIDTH`: quotient.
- `remainder`, output, `B_WIDTH`: remainder.

## Operation
- States:
  - IDLE: `complete` = 1, or 0 after reset.
  - BUSY: a cycle counter runs 0 to `NUM_CYC`-1.
- Transitions:
  - `start` high moves any state to BUSY with the counter cleared.
  - BUSY moves to IDLE when the counter reaches the end.
- The core is a restoring shift-subtract divider on operand magnitudes.
  - It retires `K = ceil(A_WIDTH / (NUM_CYC-1))` quotient bits per cycle.
  - Leftover cycles are idle padding, so latency is always exactly `NUM_CYC`.
- Signed mode (`TC_MODE`=1):
  - Both operands are converted to magnitudes first.
  - The quotient is negated when the signs of `a` and `b` differ.
  - The remainder takes the sign of `a`, giving truncation toward zero.
- Divide by zero:
  - `divide_by_0` = 1.
  - `quotient` = all ones.
  - `remainder` = `a` truncated to `B_WIDTH`, in both modes.
- `start` asserted while BUSY aborts the current operation and restarts with the current operands. No stale result is presented.
- `hold` high while BUSY and `start` low freezes the counter and datapath. `start` has priority over `hold`.
- Reset (asynchronous, any time, including mid-operation) forces:
  - IDLE state;
  - `complete` = 0, `divide_by_0` = 0;
  - `quotient` = 0, `remainder` = 0.

## Timing
- Let edge k be the rising edge that samples `start` = 1.
  - `complete` is 0 after edge k.
  - `complete` rises after edge k+`NUM_CYC`, provided no hold cycles occur. Each hold cycle adds one cycle.
- `INPUT_MODE`=1: `a`/`b` are sampled only at edge k.
- `OUTPUT_MODE`=1: `quotient`, `remainder` and `divide_by_0` update in the same cycle `complete` rises. They hold until the next completion.
- `complete` stays 1 until the next `start` is sampled.
- With `start` held high for several cycles, completion is `NUM_CYC` cycles after the last sampled start.

## Configuration
- `DW_DIV_SEQ_HOLD_EN`:
  - Defined: `hold` behaves as specified.
  - Undefined: `hold` is ignored. The port remains present, and no hold logic or counter enable is synthesised.

## Test plan
- Unsigned, defaults: a=100, b=7, single-cycle start -> `complete` rises exactly 10 cycles later, with q=14, r=2, `divide_by_0`=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF, start held high for 6 cycles -> completion 10 cycles after the last start; q=1, r=0; `complete` stays low throughout.
- a=5, b=0 -> q=0xFFFFFFFF, r=5, `divide_by_0`=1 at completion.
- `TC_MODE`=1: a=-7 (0xFFFFFFF9), b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
- Hold (macro defined): hold high for 3 cycles mid-operation -> `complete` at start+13 with the correct result. With the macro undefined -> `complete` at start+10.
- `rst_n` low mid-operation -> all outputs 0 immediately. A fresh start after release completes normally 10 cycles later.
